// File: rtl/sdram_tester_pkg.sv
// sdram_tester_pkg: shared FSM states, pattern mode encodings and LFSR constants
// for the SDRAM pattern tester.
package sdram_tester_pkg;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, DONE} state_e;
   typedef enum logic [1:0] {MODE_ADDR, MODE_INV, MODE_WALK, MODE_LFSR} mode_e;
   localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
endpackage

// File: rtl/sdram_tester_pattern.sv
// sdram_tester_pattern: data pattern for the current word; the LFSR mode is
// compiled in only when SDRAM_TESTER_LFSR_EN is defined, otherwise it mirrors address mode.
module sdram_tester_pattern
   import sdram_tester_pkg::*;
#(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed,
   input  logic              step,
   input  mode_e             mode,
   input  logic [ADDR_W-1:0] idx,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] pattern
);
   logic [DATA_W-1:0] addr_pat, walk_pat, lfsr_pat;
   assign addr_pat = DATA_W'(addr);
   assign walk_pat = DATA_W'(1) << (idx % ADDR_W'(DATA_W));
`ifdef SDRAM_TESTER_LFSR_EN
   logic [31:0] lfsr;
   // Galois form: shift right, fold taps in when the bit leaving is set
   always_ff @(posedge clk) begin
      if (rst || seed) lfsr <= LFSR_SEED;
      else if (step) lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
   end
   assign lfsr_pat = lfsr[DATA_W-1:0];
`else
   logic unused_lfsr;
   assign unused_lfsr = ^{clk, rst, seed, step};
   assign lfsr_pat = addr_pat;
`endif
   always_comb begin
      pattern = mode == MODE_INV  ? ~addr_pat :
                mode == MODE_WALK ? walk_pat  :
                mode == MODE_LFSR ? lfsr_pat  : addr_pat;
   end
endmodule

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: Wishbone master that writes a pattern over a word range,
// reads it back and counts mismatches. LFSR mode needs SDRAM_TESTER_LFSR_EN.
module sdram_pattern_tester #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 32,
   parameter int ERR_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] len_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] dat_o,
   input  logic [DATA_W-1:0] dat_i,
   output logic              we_o,
   output logic              stb_o,
   output logic              cyc_o,
   input  logic              ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic [ERR_W-1:0]  err_cnt_o,
   output logic [ADDR_W-1:0] first_err_addr_o
);
   import sdram_tester_pkg::*;
   state_e state, state_nx;
   mode_e mode_q;
   logic [ADDR_W-1:0] base_q, len_q, idx, cur_addr;
   logic [DATA_W-1:0] pat;
   logic accept, last, mism, err_any, seed, step;
   assign accept   = state == IDLE && start_i;
   assign cur_addr = base_q + idx;
   assign last     = idx == len_q - 1'b1;
   assign mism     = dat_i != pat;
   assign err_any  = err_cnt_o != '0 || mism;
   assign busy_o   = state inside {WR_REQ, WR_ACK, RD_REQ, RD_ACK};
   // LFSR restarts for each phase so reads regenerate the written sequence
   assign seed     = accept || (state == WR_ACK && ack_i && last);
   assign step     = (state == WR_ACK || state == RD_ACK) && ack_i;
   sdram_tester_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pattern (
      .clk(clk_i), .rst(rst_i), .seed(seed), .step(step),
      .mode(mode_q), .idx(idx), .addr(cur_addr), .pattern(pat)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_i) state_nx = len_i == '0 ? DONE : WR_REQ;
         WR_REQ:  state_nx = WR_ACK;
         WR_ACK:  if (ack_i) state_nx = last ? RD_REQ : WR_REQ;
         RD_REQ:  state_nx = RD_ACK;
         RD_ACK:  if (ack_i) state_nx = last ? DONE : RD_REQ;
         default: state_nx = IDLE;
      endcase
   end
   // Bus outputs are registered: raised from the REQ states, dropped after ack
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q <= MODE_ADDR;
         base_q <= '0;
         len_q <= '0;
         idx <= '0;
         addr_o <= '0;
         dat_o <= '0;
         we_o <= 1'b0;
         stb_o <= 1'b0;
         cyc_o <= 1'b0;
         done_o <= 1'b0;
         pass_o <= 1'b0;
         fail_o <= 1'b0;
         err_cnt_o <= '0;
         first_err_addr_o <= '0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               mode_q <= mode_e'(mode_i);
               base_q <= base_i;
               len_q <= len_i;
               idx <= '0;
               err_cnt_o <= '0;
               first_err_addr_o <= '0;
               done_o <= len_i == '0;
               pass_o <= len_i == '0;
               fail_o <= 1'b0;
            end
            WR_REQ, RD_REQ: begin
               cyc_o <= 1'b1;
               stb_o <= 1'b1;
               we_o <= state == WR_REQ;
               addr_o <= cur_addr;
               if (state == WR_REQ) dat_o <= pat;
            end
            WR_ACK, RD_ACK: if (ack_i) begin
               cyc_o <= 1'b0;
               stb_o <= 1'b0;
               we_o <= 1'b0;
               idx <= last ? '0 : idx + 1'b1;
               if (state == RD_ACK && mism) begin
                  err_cnt_o <= &err_cnt_o ? err_cnt_o : err_cnt_o + 1'b1;
                  if (err_cnt_o == '0) first_err_addr_o <= addr_o;
               end
               if (state == RD_ACK && last) begin
                  done_o <= 1'b1;
                  pass_o <= !err_any;
                  fail_o <= err_any;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: table-driven and randomized runs against a memory
// slave with programmable ack delay and bit-flip injection; follows SDRAM_TESTER_LFSR_EN.
module tb_sdram_pattern_tester;
   logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, ack_i = 1'b0;
   logic [1:0] mode_i = '0;
   logic [21:0] base_i = '0, len_i = '0, addr_o, first_err_addr_o;
   logic [31:0] dat_o, dat_i = '0;
   logic we_o, stb_o, cyc_o, busy_o, done_o, pass_o, fail_o;
   logic [15:0] err_cnt_o;

   sdram_pattern_tester dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
      .base_i(base_i), .len_i(len_i), .addr_o(addr_o), .dat_o(dat_o),
      .dat_i(dat_i), .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
      .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int max_delay = 0, fix_delay = -1, unstable = 0;
   bit flip_en = 0;
   logic [21:0] flip_a = '0;
   logic [21:0] wr_a[$], rd_a[$];
   logic [31:0] wr_d[$];
   logic [31:0] mem[logic [21:0]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_at(input int k);
      logic [31:0] x = 32'hACE1_0001;
      for (int j = 0; j < k; j++) x = (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
      return x;
   endfunction

   function automatic logic [31:0] pat(input int m, input int i, input logic [21:0] a);
      case (m)
         0: return {10'b0, a};
         1: return ~{10'b0, a};
         2: return 32'h1 << (i % 32);
         default:
`ifdef SDRAM_TESTER_LFSR_EN
            return lfsr_at(i);
`else
            return {10'b0, a};
`endif
      endcase
   endfunction

   // Memory slave: acks after a delay, checks request stability while waiting
   initial begin
      bit in_req = 0;
      int wcnt = 0;
      logic [54:0] cap = '0;
      forever begin
         @(negedge clk);
         if (cyc_o && stb_o && !ack_i) begin
            if (!in_req) begin
               in_req = 1;
               cap = {addr_o, dat_o, we_o};
               wcnt = fix_delay >= 0 ? fix_delay : int'($urandom_range(0, max_delay));
            end else if ({addr_o, dat_o, we_o} != cap) unstable++;
            if (wcnt == 0) begin
               ack_i = 1;
               in_req = 0;
               if (we_o) begin
                  mem[addr_o] = dat_o;
                  wr_a.push_back(addr_o);
                  wr_d.push_back(dat_o);
               end else begin
                  dat_i = mem.exists(addr_o) ? mem[addr_o] : 32'h0;
                  if (flip_en && addr_o == flip_a) dat_i[0] = ~dat_i[0];
                  rd_a.push_back(addr_o);
               end
            end else wcnt--;
         end else begin
            ack_i = 0;
            in_req = 0;
         end
      end
   end

   task automatic run(input int m, input logic [21:0] b, input logic [21:0] n,
                      input bit fl, input logic [21:0] fa, input int dly, input bit poke);
      int cnt = 0, exp_err = 0;
      logic [21:0] exp_first = '0, a;
      wr_a.delete(); wr_d.delete(); rd_a.delete();
      flip_en = fl; flip_a = fa; max_delay = dly; unstable = 0;
      @(negedge clk);
      mode_i = 2'(m); base_i = b; len_i = n; start_i = 1;
      @(negedge clk);
      start_i = 0; mode_i = ~mode_i; base_i = ~b; len_i = n + 22'd5;
      if (n != 0) chk("busy", busy_o, 1);
      while (!done_o && cnt < 4000) begin
         @(negedge clk);
         start_i = poke && cnt == 3;
         cnt++;
      end
      start_i = 0;
      chk("done_timeout", done_o, 1);
      chk("wr_count", wr_a.size(), n);
      chk("rd_count", rd_a.size(), n);
      for (int i = 0; i < int'(n) && i < wr_a.size() && i < rd_a.size(); i++) begin
         a = 22'(b + 22'(i));
         chk("wr_addr", wr_a[i], a);
         chk("wr_data", wr_d[i], pat(m, i, a));
         chk("rd_addr", rd_a[i], a);
         if (fl && a == fa) begin
            if (exp_err == 0) exp_first = a;
            exp_err++;
         end
      end
      chk("err_cnt", err_cnt_o, exp_err);
      chk("first_err", first_err_addr_o, exp_first);
      chk("pass", pass_o, exp_err == 0);
      chk("fail", fail_o, exp_err != 0);
      chk("stable", unstable, 0);
   endtask

   typedef struct {
      int mode;
      logic [21:0] base, len;
      bit fl;
      logic [21:0] fa;
      int dly;
      bit pass;
      int err;
      logic [21:0] first;
   } vec_t;
   vec_t tbl[6];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0, 22'h100, 22'd4, 0, 22'h0, 0, 1, 0, 22'h0};
      tbl[1] = '{1, 22'h100, 22'd8, 1, 22'h102, 0, 0, 1, 22'h102};
      tbl[2] = '{2, 22'h040, 22'd40, 0, 22'h0, 7, 1, 0, 22'h0};
      tbl[3] = '{0, 22'h3FFFFE, 22'd4, 0, 22'h0, 0, 1, 0, 22'h0};
      tbl[4] = '{3, 22'h200, 22'd3, 0, 22'h0, 1, 1, 0, 22'h0};
      tbl[5] = '{0, 22'h300, 22'd0, 0, 22'h0, 0, 1, 0, 22'h0};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus", {we_o, stb_o, cyc_o, addr_o}, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_stat", {busy_o, done_o, pass_o, fail_o, err_cnt_o}, 0);
      chk("rst_first", first_err_addr_o, 0);
      @(negedge clk);
      rst_i = 0;

      for (int t = 0; t < 6; t++) begin
         run(tbl[t].mode, tbl[t].base, tbl[t].len, tbl[t].fl, tbl[t].fa, tbl[t].dly, 0);
         chk("tbl_pass", pass_o, tbl[t].pass);
         chk("tbl_err", err_cnt_o, tbl[t].err);
         chk("tbl_first", first_err_addr_o, tbl[t].first);
         chk("tbl_done", done_o, 1);
         if (t == 0 && wr_d.size() == 4) chk("m0_last_word", wr_d[3], 32'h103);
         if (t == 2 && wr_d.size() > 33) chk("walk_word33", wr_d[33], 32'h2);
         if (t == 3 && wr_a.size() == 4) chk("wrap_addr", {wr_a[1], wr_a[2], wr_a[3]}, {22'h3FFFFF, 22'h0, 22'h1});
`ifdef SDRAM_TESTER_LFSR_EN
         if (t == 4 && wr_d.size() > 0) chk("lfsr_first", wr_d[0], 32'hACE1_0001);
`else
         if (t == 4 && wr_d.size() > 0) chk("lfsr_off_first", wr_d[0], 32'h200);
`endif
      end

      // Reset in the third write's ack wait, then a clean run
      begin
         int cnt = 0;
         wr_a.delete(); wr_d.delete(); rd_a.delete();
         fix_delay = 3; flip_en = 0;
         @(negedge clk);
         mode_i = 0; base_i = 22'h80; len_i = 22'd8; start_i = 1;
         @(negedge clk);
         start_i = 0;
         do begin
            @(posedge clk); #1;
            cnt++;
         end while (!(wr_a.size() == 2 && cyc_o && we_o) && cnt < 200);
         chk("rst_reach", cnt < 200, 1);
         rst_i = 1;
         @(posedge clk); #1;
         chk("mid_rst_bus", {we_o, stb_o, cyc_o}, 0);
         chk("mid_rst_stat", {busy_o, done_o, pass_o, fail_o, err_cnt_o}, 0);
         @(negedge clk);
         rst_i = 0; fix_delay = -1;
         run(1, 22'h80, 22'd6, 0, 22'h0, 2, 0);
      end

      for (int r = 0; r < 12; r++) begin
         int m = int'($urandom_range(0, 3));
         logic [21:0] b = 22'($urandom);
         logic [21:0] n = 22'($urandom_range(1, 20));
         bit fl = bit'($urandom_range(0, 1));
         logic [21:0] fa = 22'(b + 22'($urandom_range(0, int'(n) - 1)));
         if (r % 4 == 0) b = 22'h3FFFF0 + 22'($urandom_range(0, 15));
         if (r % 4 == 0) fa = 22'(b + 22'($urandom_range(0, int'(n) - 1)));
         run(m, b, n, fl, fa, int'($urandom_range(0, 3)), n >= 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
